// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, two comb reads,
// registered debug read, sequenced clear. Optional bypass: REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              clr_req,
  output logic              clr_busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W:0]   NREGS = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

  state_t            state, stateNext;
  logic [ADDR_W-1:0] clrIdx;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] stA, stB, stD;
  logic              idle, wOk0, wOk1;

  // Address maps to a real, writable register
  function automatic logic live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREGS) && !(ZERO_REG != 0 && a == '0);
  endfunction

  assign idle     = (state == IDLE);
  assign clr_busy = (state == CLEAR);
  assign wOk0     = we0 && idle && live(waddr0);
  assign wOk1     = we1 && idle && live(waddr1);

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (clr_req) stateNext = CLEAR;
      CLEAR: if (clrIdx == LAST) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clrIdx   <= '0;
      dbg_data <= '0;
    end else begin
      state    <= stateNext;
      clrIdx   <= idle ? '0 : clrIdx + ADDR_W'(1);
      dbg_data <= stD;
    end
  end

  // Port 1 wins a same-address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (clr_busy && clrIdx == ADDR_W'(i))
          regs[i] <= '0;
        else if (wOk1 && waddr1 == ADDR_W'(i))
          regs[i] <= wdata1;
        else if (wOk0 && waddr0 == ADDR_W'(i))
          regs[i] <= wdata0;
      end
    end
  end

  always_comb begin
    stA = '0;
    stB = '0;
    stD = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr_a == ADDR_W'(i)) stA = regs[i];
      if (raddr_b == ADDR_W'(i)) stB = regs[i];
      if (dbg_addr == ADDR_W'(i)) stD = regs[i];
    end
    if (!live(raddr_a)) stA = '0;
    if (!live(raddr_b)) stB = '0;
    if (!live(dbg_addr)) stD = '0;
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rdata_a = stA;
    rdata_b = stB;
    if (wOk1 && waddr1 == raddr_a)
      rdata_a = wdata1;
    else if (wOk0 && waddr0 == raddr_a)
      rdata_a = wdata0;
    if (wOk1 && waddr1 == raddr_b)
      rdata_b = wdata1;
    else if (wOk0 && waddr0 == raddr_b)
      rdata_b = wdata0;
  end
`else
  assign rdata_a = stA;
  assign rdata_b = stB;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expectations by cycle,
// a negedge monitor pops and compares them.
module tb_regfile_mp;

  localparam int SA = 0, SB = 1, SD = 2, SY = 3;

  logic        clk = 0;
  logic        rst;
  logic        we0, we1, clr_req, clr_busy;
  logic [4:0]  waddr0, waddr1, raddr_a, raddr_b, dbg_addr;
  logic [31:0] wdata0, wdata1, rdata_a, rdata_b, dbg_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          qSig [$];
  logic [31:0] qExp [$];
  int          qDue [$];
  string       qName [$];

  int          mSig, mDue;
  logic [31:0] mExp, mAct;
  string       mName;

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr_a(raddr_a), .rdata_a(rdata_a),
    .raddr_b(raddr_b), .rdata_b(rdata_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Queue entries are pushed in nondecreasing due-cycle order
  always @(negedge clk) begin
    while (qDue.size() > 0 && qDue[0] <= cyc) begin
      mSig  = qSig.pop_front();
      mExp  = qExp.pop_front();
      mDue  = qDue.pop_front();
      mName = qName.pop_front();
      case (mSig)
        SA:      mAct = rdata_a;
        SB:      mAct = rdata_b;
        SD:      mAct = dbg_data;
        default: mAct = {31'b0, clr_busy};
      endcase
      total++;
      if (mDue != cyc || mAct !== mExp) begin
        bad++;
        $display("FAIL %s: got %h want %h (due %0d seen %0d)",
                 mName, mAct, mExp, mDue, cyc);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void want(int sig, logic [31:0] exp,
                               int lat, string name);
    qSig.push_back(sig);
    qExp.push_back(exp);
    qDue.push_back(cyc + lat);
    qName.push_back(name);
  endfunction

  initial begin
    rst = 1;
    we0 = 0; waddr0 = 0; wdata0 = 0;
    we1 = 0; waddr1 = 0; wdata1 = 0;
    raddr_a = 0; raddr_b = 0; dbg_addr = 0; clr_req = 0;
    tick();
    tick();
    rst = 0;

    // Reset state everywhere
    for (int i = 0; i < 32; i++) begin
      raddr_a  = 5'(i);
      raddr_b  = 5'(31 - i);
      dbg_addr = 5'(i);
      want(SA, 0, 0, "rst_a");
      want(SB, 0, 0, "rst_b");
      want(SY, 0, 0, "rst_busy");
      want(SD, 0, 1, "rst_dbg");
      tick();
    end

    // Single write, read back and debug one cycle later
    we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; raddr_a = 1;
    want(SA, 0, 0, "rd_other");
    tick();
    we0 = 0; raddr_a = 5; dbg_addr = 5;
    want(SA, 32'hDEADBEEF, 0, "wr5_a");
    want(SD, 32'hDEADBEEF, 1, "wr5_dbg");
    tick();

    // Same-address collision: port 1 wins
    we0 = 1; waddr0 = 7; wdata0 = 32'h11;
    we1 = 1; waddr1 = 7; wdata1 = 32'h22;
    tick();
    we0 = 0; we1 = 0; raddr_a = 7;
    want(SA, 32'h22, 0, "coll_7");
    tick();
    we0 = 1; waddr0 = 7; wdata0 = 32'h11;
    we1 = 1; waddr1 = 8; wdata1 = 32'h22;
    tick();
    we0 = 0; we1 = 0; raddr_a = 7; raddr_b = 8;
    want(SA, 32'h11, 0, "dual_7");
    want(SB, 32'h22, 0, "dual_8");
    tick();

    // Hardwired zero register
    we1 = 1; waddr1 = 0; wdata1 = 32'hFFFFFFFF;
    tick();
    we1 = 0; raddr_a = 0; dbg_addr = 0;
    want(SA, 0, 0, "zero_a");
    want(SD, 0, 1, "zero_dbg");
    tick();

    // Same-cycle read of a write; debug sees the pre-write value
    we0 = 1; waddr0 = 3; wdata0 = 32'h33;
    tick();
    we0 = 1; waddr0 = 3; wdata0 = 32'h55; raddr_b = 3; dbg_addr = 3;
`ifdef REGFILE_BYPASS_EN
    want(SB, 32'h55, 0, "byp_b");
`else
    want(SB, 32'h33, 0, "byp_b");
`endif
    want(SD, 32'h33, 1, "byp_dbg");
    tick();
    we0 = 0;
    want(SB, 32'h55, 0, "after_b");
    tick();

    // Fill 1..31 with their index, then clear
    for (int i = 1; i < 32; i++) begin
      we0 = 1; waddr0 = 5'(i); wdata0 = i;
      tick();
    end
    we0 = 0; raddr_a = 17; raddr_b = 31; clr_req = 1;
    want(SA, 17, 0, "fill_17");
    want(SB, 31, 0, "fill_31");
    want(SY, 0, 0, "pre_busy");
    tick();
    clr_req = 0;
    for (int n = 0; n < 32; n++) begin
      raddr_a = 5'(n);
      raddr_b = 31;
      clr_req = (n == 3);
      we0 = (n == 5); waddr0 = 31; wdata0 = 32'hBAD;
      we1 = (n == 5); waddr1 = 30; wdata1 = 32'hBAD;
      want(SA, n, 0, "clr_a");
      want(SB, 31, 0, "clr_b");
      want(SY, 1, 0, "clr_busy");
      tick();
    end
    we0 = 0; we1 = 0; clr_req = 0;
    for (int i = 0; i < 32; i++) begin
      raddr_a  = 5'(i);
      dbg_addr = 5'(i);
      want(SA, 0, 0, "post_a");
      want(SY, 0, 0, "post_busy");
      want(SD, 0, 1, "post_dbg");
      tick();
    end

    // Reset at clear cycle 10 aborts; a new clear runs to completion
    for (int i = 0; i < 3; i++) begin
      we0 = 1; waddr0 = 5'(4 + 8 * i); wdata0 = 32'hA0 + i;
      tick();
    end
    we0 = 0; clr_req = 1;
    tick();
    clr_req = 0;
    for (int n = 0; n < 10; n++) begin
      raddr_a = 20;
      want(SA, 32'hA2, 0, "pre_abort");
      want(SY, 1, 0, "abort_busy");
      tick();
    end
    rst = 1;
    #1;
    raddr_a = 20; raddr_b = 12; dbg_addr = 4;
    want(SA, 0, 0, "abort_20");
    want(SB, 0, 0, "abort_12");
    want(SY, 0, 0, "abort_idle");
    want(SD, 0, 0, "abort_dbg");
    tick();
    rst = 0;
    we0 = 1; waddr0 = 9; wdata0 = 32'h99;
    tick();
    we0 = 0; clr_req = 1; raddr_a = 9;
    want(SA, 32'h99, 0, "reclr_pre");
    tick();
    clr_req = 0;
    for (int n = 0; n < 32; n++) begin
      want(SY, 1, 0, "reclr_busy");
      tick();
    end
    raddr_a = 9;
    want(SY, 0, 0, "reclr_done");
    want(SA, 0, 0, "reclr_9");
    tick();
    tick();

    if (qDue.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", qDue.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the 32x32 two-read/one-write file in the decode stage of the 32-bit pipeline.
- Adds two write ports with fixed priority and an optional hardwired-zero register.
- Adds a sequenced clear engine with busy handshake, a debug read port, and optional write-to-read bypass.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of registers; must be <= 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- raddr_a  in  ADDR_W  read address A
- rdata_a  out  DATA_W  read data A, combinational
- raddr_b  in  ADDR_W  read address B
- rdata_b  out  DATA_W  read data B, combinational
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data, registered
- clr_req  in  1  request a sequenced clear of all registers
- clr_busy  out  1  clear in progress; pipeline must stall

Behaviour:
- Reset (async, rst=1): all registers = 0, FSM = IDLE, clr_busy = 0, dbg_data = 0. Reset asserted mid-clear aborts the clear; result is the same as a full reset.
- Writes on rising clk, IDLE state only:
  - weN=1 writes wdataN to register waddrN.
  - If we0=we1=1 and waddr0==waddr1, port 1 wins; port 0's write is dropped.
  - If the two addresses differ, both writes land in the same cycle.
- Dropped writes:
  - Any address >= NUM_REGS.
  - Address 0 when ZERO_REG=1.
- Reads A/B: combinational.
  - Address >= NUM_REGS returns 0.
  - Address 0 returns 0 when ZERO_REG=1.
  - A and B are fully independent and may alias each other.
- Debug port: dbg_data <= contents[dbg_addr] each rising edge; one-cycle latency; pre-write value of that edge.
- Clear FSM, states IDLE, CLEAR:
  - IDLE: clr_req=1 at rising edge -> CLEAR; index cleared to 0; clr_busy=1 from the next cycle.
  - CLEAR: each cycle writes 0 to register[index] and increments index. After index NUM_REGS-1 is cleared -> IDLE; clr_busy=0.
  - clr_busy is high for exactly NUM_REGS cycles.
  - Writes on we0/we1 during CLEAR are ignored; the caller must stall on clr_busy.
  - clr_req during CLEAR is ignored; no re-trigger.
  - Reads during CLEAR return current array contents (partially cleared).
- Width rules: no truncation or extension; all data is DATA_W bits.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: rdata_a/rdata_b return same-cycle write data when raddr matches an accepted write.
  - Port 1 has priority over port 0.
  - Never applies to address 0 with ZERO_REG=1, to out-of-range addresses, or during CLEAR.
  - Read-after-write needs zero bubble cycles.
- Undefined: reads return the stored value; a write becomes visible one cycle after its clk edge. dbg_data is never bypassed in either build.

Test Plan:
- Reset then read all addresses on A, B and debug -> all 0; clr_busy=0.
- we0=1, waddr0=5, wdata0=0xDEADBEEF; next cycle raddr_a=5 -> rdata_a=0xDEADBEEF; dbg_addr=5 -> dbg_data=0xDEADBEEF one cycle later.
- we0=we1=1, both addresses 7, wdata0=0x11, wdata1=0x22 -> reg 7 = 0x22. Repeat with addresses 7/8 -> reg 7 = 0x11, reg 8 = 0x22.
- ZERO_REG=1: write 0xFFFFFFFF to reg 0 -> rdata_a(0)=0. Bypass build: same-cycle write 0x55 to reg 3 with raddr_b=3 -> rdata_b=0x55 (non-bypass build: old value).
- Fill regs 1..31 with their index, pulse clr_req one cycle:
  - clr_busy high exactly 32 cycles.
  - Write attempted during busy is ignored.
  - Afterwards all regs = 0.
- Assert rst at clear cycle 10 -> all regs 0, clr_busy=0 immediately; a new clr_req after reset completes normally.
